// File: rtl/spike_rate_decoder_if.sv
// Handshake/data bundle between a spike source and spike_rate_decoder.
// The decoder is the slave; whoever drives en/spike/window_len is the master.
interface spike_rate_decoder_if;
  logic       en;
  logic       spike;
  logic [7:0] window_len;
  logic [7:0] rate;
  logic [7:0] first_spike;
  logic       spike_seen;
  logic       valid;
  logic       busy;

  modport master (
    output en, spike, window_len,
    input  rate, first_spike, spike_seen, valid, busy
  );

  modport slave (
    input  en, spike, window_len,
    output rate, first_spike, spike_seen, valid, busy
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes over a programmable window and records time-to-first-spike,
// emitting one-cycle valid strobes with the results of each completed window.
module spike_rate_decoder (
  input  logic                  clk,
  input  logic                  rst,
  spike_rate_decoder_if.slave   bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [8:0]  len_q;
  logic [7:0]  t_q;
  logic [8:0]  cnt_q;
  logic [7:0]  first_q;
  logic        seen_q;
  logic [7:0]  rate_q;
  logic [7:0]  first_spike_q;
  logic        spike_seen_q;
  logic        valid_q;

  logic        busy;
  logic        last;
  logic        win_end;
  logic        load;
  logic [8:0]  len_next;
  logic [8:0]  cnt_next;
  logic        seen_now;
  logic [7:0]  first_now;

  // A programmed length of 0 stands for a full 256-cycle window.
  assign len_next  = (bus.window_len == 8'd0) ? 9'd256 : {1'b0, bus.window_len};
  assign last      = ({1'b0, t_q} == (len_q - 9'd1));
  assign cnt_next  = cnt_q + {8'd0, bus.spike};
  assign seen_now  = seen_q | bus.spike;
  assign first_now = seen_q ? first_q : t_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.en) state_d = StRun;
      StRun:  if (last && !bus.en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control outputs
  always_comb begin
    busy    = 1'b0;
    win_end = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: load = bus.en;
      StRun: begin
        busy    = 1'b1;
        win_end = last;
        load    = last && bus.en;
      end
      default: ;
    endcase
  end

  // Window datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q         <= 9'd0;
      t_q           <= 8'd0;
      cnt_q         <= 9'd0;
      first_q       <= 8'd0;
      seen_q        <= 1'b0;
      rate_q        <= 8'd0;
      first_spike_q <= 8'hFF;
      spike_seen_q  <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (win_end) begin
        // Only 256 spikes in a 256-cycle window can set bit 8.
        rate_q        <= cnt_next[8] ? 8'hFF : cnt_next[7:0];
        first_spike_q <= seen_now ? first_now : 8'hFF;
        spike_seen_q  <= seen_now;
        valid_q       <= 1'b1;
      end
      if (load) begin
        len_q   <= len_next;
        t_q     <= 8'd0;
        cnt_q   <= 9'd0;
        first_q <= 8'd0;
        seen_q  <= 1'b0;
      end else if (busy && !win_end) begin
        t_q   <= t_q + 8'd1;
        cnt_q <= cnt_next;
        if (bus.spike && !seen_q) begin
          first_q <= t_q;
          seen_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.rate        = rate_q;
  assign bus.first_spike = first_spike_q;
  assign bus.spike_seen  = spike_seen_q;
  assign bus.valid       = valid_q;
  assign bus.busy        = busy;

endmodule
